// File: rtl/stopwatch_ctrl.sv
// Stopwatch control core: BCD MM:SS counter, idle chase animation, user target
// time and overflow/target/illegal-change flags for the downstream display stages.
module stopwatch_ctrl #(
  parameter int unsigned CLK_PER_SEC = 50_000_000,
  parameter int unsigned CHASE_DIV   = 6_250_000,
  parameter int unsigned ERR_CYC     = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_stop,
  input  logic        btn_clear,
  input  logic        btn_set,
  input  logic        btn_inc,
  input  logic [1:0]  dsel,
  output logic [15:0] cnt_d,
  output logic [15:0] set_d,
  output logic [2:0]  chase,
  output logic        signal,
  output logic        mood,
  output logic        err_over,
  output logic        err_over_time,
  output logic        err_chg
);

  localparam int unsigned PSC_W   = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
  localparam int unsigned CHASE_W = (CHASE_DIV > 1) ? $clog2(CHASE_DIV) : 1;
  localparam int unsigned ERR_W   = $clog2(ERR_CYC + 1);

  localparam logic [PSC_W-1:0]   PSC_LAST   = PSC_W'(CLK_PER_SEC - 1);
  localparam logic [CHASE_W-1:0] CHASE_LAST = CHASE_W'(CHASE_DIV - 1);
  localparam logic [ERR_W-1:0]   ERR_LOAD   = ERR_W'(ERR_CYC);
  localparam logic [15:0]        CNT_MAX    = 16'h9959;
  localparam logic [2:0]         CHASE_TOP  = 3'd6;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_PAUSE = 3'd2;
  localparam logic [2:0] ST_SET   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_OVER  = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [15:0]        count_q, count_d;
  logic [15:0]        target_q, target_d;
  logic [PSC_W-1:0]   psc_q, psc_d;
  logic [2:0]         chase_q, chase_d;
  logic [CHASE_W-1:0] chase_div_q, chase_div_d;
  logic [ERR_W-1:0]   err_tmr_q, err_tmr_d;
  logic               signal_q, signal_d;
  logic               mood_q, mood_d;
  logic               err_over_q, err_over_d;
  logic               err_ot_q, err_ot_d;
  logic               err_chg_q, err_chg_d;

  logic [15:0]        count_inc;
  logic [15:0]        target_inc;
  logic               sec_tick;
  logic               at_max;
  logic               err_trig;

  // One-second tick and top-of-range detection for the running counter
  always_comb begin
    sec_tick = (psc_q == PSC_LAST);
    at_max   = (count_q == CNT_MAX);
  end

  // BCD increment of the count with carries s1 -> s10 -> m1 -> m10
  always_comb begin
    count_inc = count_q;
    if (count_q[3:0] >= 4'd9) begin
      count_inc[3:0] = 4'd0;
      if (count_q[7:4] >= 4'd5) begin
        count_inc[7:4] = 4'd0;
        if (count_q[11:8] >= 4'd9) begin
          count_inc[11:8]  = 4'd0;
          count_inc[15:12] = count_q[15:12] + 4'd1;
        end else begin
          count_inc[11:8] = count_q[11:8] + 4'd1;
        end
      end else begin
        count_inc[7:4] = count_q[7:4] + 4'd1;
      end
    end else begin
      count_inc[3:0] = count_q[3:0] + 4'd1;
    end
  end

  // Per-digit target increment, each digit wraps within its own range
  always_comb begin
    target_inc = target_q;
    case (dsel)
      2'd0: target_inc[3:0]   = (target_q[3:0]   >= 4'd9) ? 4'd0 : target_q[3:0]   + 4'd1;
      2'd1: target_inc[7:4]   = (target_q[7:4]   >= 4'd5) ? 4'd0 : target_q[7:4]   + 4'd1;
      2'd2: target_inc[11:8]  = (target_q[11:8]  >= 4'd9) ? 4'd0 : target_q[11:8]  + 4'd1;
      default: target_inc[15:12] = (target_q[15:12] >= 4'd9) ? 4'd0 : target_q[15:12] + 4'd1;
    endcase
  end

  // Next-state logic: mode transitions, count, target and seconds prescaler
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    psc_d    = psc_q;
    err_trig = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (btn_clear) begin
          count_d = '0;
        end else if (btn_start) begin
          state_d = ST_RUN;
        end else if (btn_set) begin
          state_d = ST_SET;
        end
      end

      ST_RUN: begin
        if (sec_tick) begin
          psc_d = '0;
          if (at_max) begin
            state_d = ST_OVER;
          end else begin
            count_d = count_inc;
            if ((target_q != '0) && (count_inc == target_q)) begin
              state_d = ST_DONE;
            end
          end
        end else begin
          psc_d = psc_q + PSC_W'(1);
        end

        // Buttons only act when the tick did not end the run
        if (state_d == ST_RUN) begin
          if (btn_clear) begin
            state_d = ST_IDLE;
            count_d = '0;
            psc_d   = '0;
          end else if (btn_stop) begin
            state_d = ST_PAUSE;
            if (!sec_tick) begin
              psc_d = psc_q;
            end
          end else if (btn_start) begin
            state_d = ST_RUN;
          end else if (btn_set || btn_inc) begin
            err_trig = 1'b1;
          end
        end
      end

      ST_PAUSE: begin
        if (btn_clear) begin
          state_d = ST_IDLE;
          count_d = '0;
          psc_d   = '0;
        end else if (btn_start) begin
          state_d = ST_RUN;
        end else if (btn_set) begin
          state_d = ST_SET;
        end
      end

      ST_SET: begin
        if (btn_clear) begin
          target_d = '0;
        end else if (btn_set) begin
          state_d = (count_q != '0) ? ST_PAUSE : ST_IDLE;
        end else if (btn_inc) begin
          target_d = target_inc;
        end
      end

      ST_DONE, ST_OVER: begin
        if (btn_clear) begin
          state_d = ST_IDLE;
          count_d = '0;
          psc_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        count_d = '0;
        psc_d   = '0;
      end
    endcase

    // A fresh start from IDLE always begins a whole second
    if (state_d == ST_IDLE) begin
      psc_d = '0;
    end
  end

  // Chase animation: steps only while resting in IDLE, zero otherwise
  always_comb begin
    chase_d     = chase_q;
    chase_div_d = chase_div_q;
    if ((state_q == ST_IDLE) && (state_d == ST_IDLE)) begin
      if (chase_div_q == CHASE_LAST) begin
        chase_div_d = '0;
        chase_d     = (chase_q >= CHASE_TOP) ? 3'd0 : chase_q + 3'd1;
      end else begin
        chase_div_d = chase_div_q + CHASE_W'(1);
      end
    end else begin
      chase_d     = '0;
      chase_div_d = '0;
    end
  end

  // Illegal-change window timer, restarted by every new attempt
  always_comb begin
    err_tmr_d = err_tmr_q;
    if (err_trig) begin
      err_tmr_d = ERR_LOAD;
    end else if (err_tmr_q != '0) begin
      err_tmr_d = err_tmr_q - ERR_W'(1);
    end
  end

  // Display-control flags decoded from the next state
  always_comb begin
    signal_d   = (state_d == ST_IDLE);
    mood_d     = (state_d == ST_SET) || (state_d == ST_DONE);
    err_over_d = (state_d == ST_OVER);
    err_ot_d   = (state_d == ST_DONE);
    err_chg_d  = (err_tmr_d != '0);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      target_q    <= '0;
      psc_q       <= '0;
      chase_q     <= '0;
      chase_div_q <= '0;
      err_tmr_q   <= '0;
      signal_q    <= 1'b1;
      mood_q      <= 1'b0;
      err_over_q  <= 1'b0;
      err_ot_q    <= 1'b0;
      err_chg_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      target_q    <= target_d;
      psc_q       <= psc_d;
      chase_q     <= chase_d;
      chase_div_q <= chase_div_d;
      err_tmr_q   <= err_tmr_d;
      signal_q    <= signal_d;
      mood_q      <= mood_d;
      err_over_q  <= err_over_d;
      err_ot_q    <= err_ot_d;
      err_chg_q   <= err_chg_d;
    end
  end

  assign cnt_d         = count_q;
  assign set_d         = target_q;
  assign chase         = chase_q;
  assign signal        = signal_q;
  assign mood          = mood_q;
  assign err_over      = err_over_q;
  assign err_over_time = err_ot_q;
  assign err_chg       = err_chg_q;

endmodule
